// File: rtl/sd_pkg.sv
// SD SPI-mode command sequencer: shared types and constants.
// Holds FSM states, error codes, token/fill bytes and the fixed CRC table.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_RESP  = 3'd2,
    ST_TOKEN = 3'd3,
    ST_DATA  = 3'd4,
    ST_CRC   = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_R1TO  = 2'b01;
  localparam logic [1:0] ERR_TOKTO = 2'b10;
  localparam logic [1:0] ERR_TOKEN = 2'b11;

  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] FILL        = 8'hFF;
  localparam int         BLK_LEN     = 512;

  // Precomputed trailer bytes for the only commands that need a valid CRC
  // before CRC checking is switched off on the card.
  function automatic logic [7:0] fixed_crc_byte(input logic [5:0] idx);
    logic [7:0] b;
    b = FILL;
    if (idx == 6'd0) b = 8'h95;
    if (idx == 6'd8) b = 8'h87;
    return b;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 (x^7 + x^3 + 1, init 0) for the SD command frame.
// Combinational 8-bit update feeding a registered accumulator.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  // Fold one byte into the running CRC, MSB first.
  always_comb begin
    logic fb;
    crc_d = crc_q;
    for (int i = 7; i >= 0; i--) begin
      fb    = crc_d[6] ^ data[i];
      crc_d = {crc_d[5:0], 1'b0};
      if (fb) crc_d = crc_d ^ 7'h09;
    end
  end

  // Accumulator, cleared at the start of each command.
  always_ff @(posedge clk) begin
    if (reset || clr) crc_q <= 7'd0;
    else if (en)      crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command sequencer: frame, R1 poll, token wait, 512-byte read.
// Define SD_CRC7_EN to compute the frame CRC7; otherwise a fixed table is used.
module sd_cmd_seq
  import sd_pkg::*;
#(
  parameter int RESP_POLL  = 8,
  parameter int TOKEN_POLL = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_rdblk,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic [1:0]  err,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        spi_go,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx
);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        rdblk_q, rdblk_d;
  logic [7:0]  cnt8_q, cnt8_d;
  logic [11:0] cnt12_q, cnt12_d;
  logic        pend_q, pend_d;
  logic        go_q, go_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  r1_q, r1_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rdd_q, rdd_d;
  logic        rdv_q, rdv_d;
  logic        accept;
  logic        issue;
  logic [7:0]  frame_b;
  logic [7:0]  crc_b;

`ifdef SD_CRC7_EN
  logic [6:0] crc7;

  sd_crc7 u_crc7 (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (issue && (state_q == ST_SEND) && (cnt8_q < 8'd5)),
    .data  (frame_b),
    .crc   (crc7)
  );

  assign crc_b = {crc7, 1'b1};
`else
  assign crc_b = fixed_crc_byte(idx_q);
`endif

  // Select the command frame byte addressed by the SEND counter.
  always_comb begin
    frame_b = crc_b;
    unique case (cnt8_q)
      8'd0:    frame_b = {2'b01, idx_q};
      8'd1:    frame_b = arg_q[31:24];
      8'd2:    frame_b = arg_q[23:16];
      8'd3:    frame_b = arg_q[15:8];
      8'd4:    frame_b = arg_q[7:0];
      default: frame_b = crc_b;
    endcase
  end

  // Next-state logic: one byte in flight at a time, handled on spi_done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    rdblk_d = rdblk_q;
    cnt8_d  = cnt8_q;
    cnt12_d = cnt12_q;
    pend_d  = pend_q;
    go_d    = 1'b0;
    tx_d    = tx_q;
    r1_d    = r1_q;
    err_d   = err_q;
    rdd_d   = rdd_q;
    rdv_d   = 1'b0;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          accept  = 1'b1;
          idx_d   = cmd_idx;
          arg_d   = cmd_arg;
          rdblk_d = cmd_rdblk;
          r1_d    = FILL;
          err_d   = ERR_OK;
          cnt8_d  = 8'd0;
          cnt12_d = 12'd0;
          pend_d  = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        if (!pend_q) begin
          issue  = 1'b1;
          go_d   = 1'b1;
          pend_d = 1'b1;
          tx_d   = (state_q == ST_SEND) ? frame_b : FILL;
        end else if (spi_done) begin
          pend_d = 1'b0;
          unique case (state_q)
            ST_SEND: begin
              if (cnt8_q == 8'd5) begin
                cnt8_d  = 8'd0;
                state_d = ST_RESP;
              end else begin
                cnt8_d = cnt8_q + 8'd1;
              end
            end
            ST_RESP: begin
              if (!spi_rx[7]) begin
                r1_d = spi_rx;
                if (!rdblk_q || (spi_rx > 8'h01)) begin
                  err_d   = ERR_OK;
                  state_d = ST_FIN;
                end else begin
                  cnt12_d = 12'd0;
                  state_d = ST_TOKEN;
                end
              end else if (cnt8_q == 8'(RESP_POLL - 1)) begin
                r1_d    = FILL;
                err_d   = ERR_R1TO;
                state_d = ST_FIN;
              end else begin
                cnt8_d = cnt8_q + 8'd1;
              end
            end
            ST_TOKEN: begin
              if (spi_rx == START_TOKEN) begin
                cnt12_d = 12'd0;
                state_d = ST_DATA;
              end else if (spi_rx[7:4] == 4'd0 && spi_rx[3:0] != 4'd0) begin
                err_d   = ERR_TOKEN;
                state_d = ST_FIN;
              end else if (cnt12_q == 12'(TOKEN_POLL - 1)) begin
                err_d   = ERR_TOKTO;
                state_d = ST_FIN;
              end else begin
                cnt12_d = cnt12_q + 12'd1;
              end
            end
            ST_DATA: begin
              rdv_d = 1'b1;
              rdd_d = spi_rx;
              if (cnt12_q == 12'(BLK_LEN - 1)) begin
                cnt8_d  = 8'd0;
                state_d = ST_CRC;
              end else begin
                cnt12_d = cnt12_q + 12'd1;
              end
            end
            ST_CRC: begin
              if (cnt8_q == 8'd1) state_d = ST_FIN;
              else                cnt8_d  = cnt8_q + 8'd1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      arg_q   <= 32'd0;
      rdblk_q <= 1'b0;
      cnt8_q  <= 8'd0;
      cnt12_q <= 12'd0;
      pend_q  <= 1'b0;
      go_q    <= 1'b0;
      tx_q    <= FILL;
      r1_q    <= FILL;
      err_q   <= ERR_OK;
      rdd_q   <= 8'd0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      rdblk_q <= rdblk_d;
      cnt8_q  <= cnt8_d;
      cnt12_q <= cnt12_d;
      pend_q  <= pend_d;
      go_q    <= go_d;
      tx_q    <= tx_d;
      r1_q    <= r1_d;
      err_q   <= err_d;
      rdd_q   <= rdd_d;
      rdv_q   <= rdv_d;
    end
  end

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done     = (state_q == ST_FIN);
  assign r1       = r1_q;
  assign err      = err_q;
  assign rd_data  = rdd_q;
  assign rd_valid = rdv_q;
  assign spi_go   = go_q;
  assign spi_tx   = tx_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Testbench for sd_cmd_seq: table of commands against a scripted SPI engine,
// plus reset-abort and reset-state sequences.
module tb_sd_cmd_seq;

  localparam int M_CMD0   = 0;
  localparam int M_R1_01  = 1;
  localparam int M_RD     = 2;
  localparam int M_ALLFF  = 3;
  localparam int M_ERRTOK = 4;
  localparam int M_R1_04  = 5;
  localparam int M_TOKTO  = 6;
  localparam int M_LATE   = 7;
  localparam int LIMIT    = 40000;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        rdblk;
    int          mode;
    int          poke;
    int          f6;
    logic [7:0]  r1;
    logic [1:0]  err;
    int          gos;
    int          rdv;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_idx = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        cmd_rdblk = 1'b0;
  logic        busy, done, rd_valid, spi_go;
  logic [7:0]  r1, rd_data, spi_tx;
  logic [1:0]  err;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx = 8'hFF;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] tx_log[$];
  int mode = M_CMD0;
  int bidx = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int rd_bad = 0;
  int proto_bad = 0;
  int busy_bad = 0;

  vec_t vt[9];

  sd_cmd_seq dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_start (cmd_start),
    .cmd_idx   (cmd_idx),
    .cmd_arg   (cmd_arg),
    .cmd_rdblk (cmd_rdblk),
    .busy      (busy),
    .done      (done),
    .r1        (r1),
    .err       (err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .spi_go    (spi_go),
    .spi_tx    (spi_tx),
    .spi_done  (spi_done),
    .spi_rx    (spi_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] rsp(input int m, input int i);
    logic [7:0] v;
    v = 8'hFF;
    if (i >= 6) begin
      case (m)
        M_CMD0:   if (i == 7) v = 8'h01;
        M_R1_01:  if (i == 6) v = 8'h01;
        M_RD: begin
          if (i == 6)                  v = 8'h00;
          else if (i == 10)            v = 8'hFE;
          else if (i > 10 && i < 523)  v = 8'(i - 11);
        end
        M_ERRTOK: begin
          if (i == 6) v = 8'h00;
          if (i == 7) v = 8'h05;
        end
        M_R1_04:  if (i == 6) v = 8'h04;
        M_TOKTO:  if (i == 6) v = 8'h01;
        M_LATE:   if (i == 13) v = 8'h00;
        default:  v = 8'hFF;
      endcase
    end
    return v;
  endfunction

  function automatic logic [7:0] f6_ref(input logic [5:0] idx,
                                        input logic [31:0] arg);
    logic [39:0] bits;
    logic [6:0]  c;
    logic        fb;
    bits = {2'b01, idx, arg};
    c = 7'd0;
    for (int b = 39; b >= 0; b--) begin
      fb = c[6] ^ bits[b];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
`ifdef SD_CRC7_EN
    return {c, 1'b1};
`else
    if (idx == 6'd0) return 8'h95;
    if (idx == 6'd8) return 8'h87;
    return 8'hFF;
`endif
  endfunction

  // Scripted SPI byte engine plus output monitors, all at the falling edge.
  initial begin : engine
    int         wait_c;
    logic [7:0] pend_rx;
    logic       outst;
    wait_c = 0;
    pend_rx = 8'hFF;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      outst = (wait_c > 0);
      if (wait_c > 0) begin
        wait_c--;
        if (wait_c == 0) begin
          spi_done = 1'b1;
          spi_rx = pend_rx;
        end
      end
      if (spi_go) begin
        if (outst) proto_bad++;
        tx_log.push_back(spi_tx);
        pend_rx = rsp(mode, bidx);
        bidx++;
        wait_c = 2;
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_bad++;
      end
      if (rd_valid) begin
        if (rd_data != 8'(rd_cnt)) rd_bad++;
        rd_cnt++;
      end
    end
  end

  task automatic clear_obs(input int m);
    tx_log.delete();
    mode = m;
    bidx = 0;
    done_cnt = 0;
    rd_cnt = 0;
    rd_bad = 0;
    proto_bad = 0;
    busy_bad = 0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int n;
    int fill_bad;
    logic [47:0] fa, fe;
    logic [7:0] e6;
    clear_obs(v.mode);
    @(negedge clk);
    cmd_idx = v.idx;
    cmd_arg = v.arg;
    cmd_rdblk = v.rdblk;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_idx = 6'd0;
    cmd_arg = 32'd0;
    cmd_rdblk = 1'b0;
    chk($sformatf("v%0d busy_rise", k), 64'(busy), 64'd1);
    n = 0;
    while (done_cnt == 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (v.poke != 0 && n == v.poke) begin
        cmd_idx = 6'd17;
        cmd_arg = 32'hDEADBEEF;
        cmd_rdblk = 1'b1;
        cmd_start = 1'b1;
      end else begin
        cmd_start = 1'b0;
        cmd_idx = 6'd0;
        cmd_arg = 32'd0;
        cmd_rdblk = 1'b0;
      end
    end
    cmd_start = 1'b0;
    chk($sformatf("v%0d timeout", k), 64'(n < LIMIT), 64'd1);
    repeat (10) @(negedge clk);
    e6 = (v.f6 < 0) ? f6_ref(v.idx, v.arg) : 8'(v.f6);
    fe = {2'b01, v.idx, v.arg, e6};
    fa = '0;
    if (tx_log.size() >= 6)
      fa = {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4], tx_log[5]};
    fill_bad = 0;
    for (int i = 6; i < tx_log.size(); i++)
      if (tx_log[i] != 8'hFF) fill_bad++;
    chk($sformatf("v%0d frame", k), 64'(fa), 64'(fe));
    chk($sformatf("v%0d spi_go_count", k), 64'(tx_log.size()), 64'(v.gos));
    chk($sformatf("v%0d fill_bytes", k), 64'(fill_bad), 64'd0);
    chk($sformatf("v%0d r1", k), 64'(r1), 64'(v.r1));
    chk($sformatf("v%0d err", k), 64'(err), 64'(v.err));
    chk($sformatf("v%0d rd_valid_count", k), 64'(rd_cnt), 64'(v.rdv));
    chk($sformatf("v%0d rd_data_order", k), 64'(rd_bad), 64'd0);
    chk($sformatf("v%0d done_count", k), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d go_overlap", k), 64'(proto_bad), 64'd0);
    chk($sformatf("v%0d busy_at_done", k), 64'(busy_bad), 64'd0);
    chk($sformatf("v%0d busy_after", k), 64'(busy), 64'd0);
  endtask

  initial begin : main
    int n;
    int go_at_reset;

    vt[0] = '{6'd0,  32'h0,        1'b0, M_CMD0,   0, 'h95, 8'h01, 2'b00, 8,    0};
    vt[1] = '{6'd8,  32'h000001AA, 1'b0, M_R1_01,  0, 'h87, 8'h01, 2'b00, 7,    0};
    vt[2] = '{6'd17, 32'h0,        1'b1, M_RD,     0, -1,   8'h00, 2'b00, 525,  512};
    vt[3] = '{6'd55, 32'h0,        1'b0, M_ALLFF,  0, -1,   8'hFF, 2'b01, 14,   0};
    vt[4] = '{6'd17, 32'h12345678, 1'b1, M_ERRTOK, 0, -1,   8'h00, 2'b11, 8,    0};
    vt[5] = '{6'd17, 32'h0,        1'b1, M_R1_04,  0, -1,   8'h04, 2'b00, 7,    0};
    vt[6] = '{6'd17, 32'h0,        1'b1, M_TOKTO,  0, -1,   8'h01, 2'b10, 4102, 0};
    vt[7] = '{6'd13, 32'hAABBCCDD, 1'b0, M_LATE,   0, -1,   8'h00, 2'b00, 14,   0};
    vt[8] = '{6'd0,  32'h0,        1'b0, M_CMD0,   5, 'h95, 8'h01, 2'b00, 8,    0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst rd_valid", 64'(rd_valid), 64'd0);
    chk("rst spi_go", 64'(spi_go), 64'd0);
    chk("rst spi_tx", 64'(spi_tx), 64'hFF);
    chk("rst r1", 64'(r1), 64'hFF);
    chk("rst err", 64'(err), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 9; k++) run_vec(k, vt[k]);

    clear_obs(M_RD);
    @(negedge clk);
    cmd_idx = 6'd17;
    cmd_arg = 32'h0;
    cmd_rdblk = 1'b1;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_rdblk = 1'b0;
    n = 0;
    while (rd_cnt < 100 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("abort reach_byte100", 64'(n < LIMIT), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    go_at_reset = tx_log.size();
    repeat (20) @(negedge clk);
    chk("abort no_done", 64'(done_cnt), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort r1", 64'(r1), 64'hFF);
    chk("abort err", 64'(err), 64'd0);
    chk("abort no_go", 64'(tx_log.size()), 64'(go_at_reset));
    run_vec(9, vt[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sd_cmd_seq.md
SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

Interface
REQ-001 SHALL have parameter RESP_POLL, default 8: maximum R1 poll bytes after the command frame.
REQ-002 SHALL have parameter TOKEN_POLL, default 4095: maximum poll bytes while waiting for the data token.
REQ-003 SHALL have port clk, in, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, in, 1: reset, synchronous, active-high.
REQ-005 SHALL have port cmd_start, in, 1: one-cycle command request.
REQ-006 SHALL have port cmd_idx, in, 6: SD command index.
REQ-007 SHALL have port cmd_arg, in, 32: command argument.
REQ-008 SHALL have port cmd_rdblk, in, 1: the command returns one 512-byte data block.
REQ-009 SHALL have port busy, out, 1: sequence in progress.
REQ-010 SHALL have port done, out, 1: one-cycle completion pulse.
REQ-011 SHALL have port r1, out, 8: captured R1 response.
REQ-012 SHALL have port err, out, 2: 00 ok, 01 R1 timeout, 10 token timeout, 11 error token.
REQ-013 SHALL have ports rd_data, out, 8 and rd_valid, out, 1: data-block byte stream.
REQ-014 SHALL have ports spi_go, out, 1 and spi_tx, out, 8: byte request to the SPI byte engine.
REQ-015 SHALL have ports spi_done, in, 1 and spi_rx, in, 8: engine byte-complete pulse and received byte.

Function
REQ-016 SHALL sample cmd_start only in IDLE; cmd_start while busy is ignored.
REQ-017 SHALL latch cmd_idx, cmd_arg and cmd_rdblk on the accepted cmd_start and raise busy the next cycle.
REQ-018 SHALL issue exactly one spi_go pulse per byte and issue the next spi_go no earlier than the cycle after spi_done.
REQ-019 SHALL use states IDLE, SEND, RESP, TOKEN, DATA, CRC and FIN.
REQ-020 SEND: six bytes {01,idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7,1}, MSB byte first.
REQ-021 RESP: send 0xFF; first spi_rx with bit7=0 is latched into r1; otherwise after RESP_POLL bytes go to FIN with err=01 and r1=0xFF.
REQ-022 After a valid R1: if cmd_rdblk=0 or r1 is nonzero other than 0x01 (idle bit), go to FIN with err=00.
REQ-023 TOKEN: send 0xFF; 0xFE enters DATA; a byte matching 0000xxxx with nonzero low nibble ends with err=11; otherwise TOKEN_POLL bytes without a token end with err=10.
REQ-024 DATA: send 0xFF 512 times; each spi_rx drives rd_data with a one-cycle rd_valid in the cycle after spi_done.
REQ-025 CRC: clock two 0xFF bytes and discard them, then go to FIN.
REQ-026 FIN: pulse done for one cycle, drop busy in the same cycle, hold r1/err until the next accepted cmd_start, and return to IDLE.
REQ-027 SHALL use an 8-bit byte counter for SEND/RESP and a 12-bit counter for TOKEN/DATA, both cleared on each state entry.
REQ-028 SHALL ignore spi_done outside an outstanding spi_go.

Reset
REQ-029 SHALL on reset force IDLE, busy=0, done=0, rd_valid=0, spi_go=0, spi_tx=0xFF, r1=0xFF, err=00 and both counters to 0.
REQ-030 SHALL on reset mid-sequence abandon the sequence without a done pulse; a late spi_done is ignored per REQ-028.

Configuration
REQ-031 With SD_CRC7_EN defined: frame byte 6 SHALL be the CRC7 (polynomial x^7+x^3+1, init 0) over bytes 1-5, shifted left, OR 1.
REQ-032 Without SD_CRC7_EN: byte 6 SHALL be 0x95 for idx 0, 0x87 for idx 8, else 0xFF; no CRC logic is instantiated.

Structure
REQ-033 Package sd_pkg SHALL hold the state enum, the err codes, and the constants START_TOKEN=0xFE, FILL=0xFF and BLK_LEN=512.
REQ-034 CRC7 SHALL be the sub-module sd_crc7 (byte-serial, combinational update over 8 bits, registered accumulator), instantiated only under SD_CRC7_EN.

Verification
REQ-035 CMD0, arg 0 -> spi_tx sequence 40 00 00 00 00 95; engine returns FF then 01 -> r1=01, err=00, done once, 8 spi_go total.
REQ-036 CMD8, arg 0x000001AA with SD_CRC7_EN -> byte 6 = 0x87; same result without the macro.
REQ-037 CMD17, rdblk=1; R1=00, three FF bytes then FE, data 00..FF repeating -> 512 rd_valid pulses in order, 2 CRC bytes, err=00.
REQ-038 Engine returns all FF -> after 6+8 bytes err=01, r1=FF; for CMD17 with token 0x05 -> err=11 and no rd_valid.
REQ-039 Assert reset at data byte 100, then issue a new CMD0 -> no done for the aborted sequence, clean frame 40 00 00 00 00 95.
REQ-040 cmd_start pulsed while busy -> ignored; latched arg unchanged; exactly one done.
